// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V write-back stage.
package riscv_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } load_funct3_e;

  typedef enum logic {
    IDLE       = 1'b0,
    WAIT_RDATA = 1'b1
  } wb_state_e;

endpackage

// File: rtl/riscv_load_align.sv
// Combinational load-data aligner: picks the byte/halfword lane, extends it,
// and flags misaligned accesses and unknown load encodings.
module riscv_load_align
  import riscv_pkg::*;
(
  input  logic [WORD_SIZE-1:0] rdata,
  input  logic [2:0]           funct3,
  input  logic [1:0]           addr,
  output logic [WORD_SIZE-1:0] data,
  output logic                 fault
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = rdata[7:0];
    case (addr)
      2'd0: byte_val = rdata[7:0];
      2'd1: byte_val = rdata[15:8];
      2'd2: byte_val = rdata[23:16];
      2'd3: byte_val = rdata[31:24];
      default: byte_val = rdata[7:0];
    endcase
    half_val = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data  = '0;
    fault = 1'b0;
    case (funct3)
      LB:  data = {{24{byte_val[7]}}, byte_val};
      LBU: data = {24'd0, byte_val};
      LH: begin
        data  = {{16{half_val[15]}}, half_val};
        fault = addr[0];
      end
      LHU: begin
        data  = {16'd0, half_val};
        fault = addr[0];
      end
      LW: begin
        data  = rdata;
        fault = (addr != 2'd0);
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_wb.sv
// Write-back stage: registers the RF write for ALU results and aligned loads,
// stalling while a late load response is outstanding. RISCV_WB_INSTRET_EN adds instret_o.
module riscv_wb
  import riscv_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  flush_i,
  input  logic [WORD_SIZE-1:0]  alu_out_i,
  input  logic                  is_load_i,
  input  logic [2:0]            funct3_i,
  input  logic                  reg_write_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [WORD_SIZE-1:0]  mem_rdata_i,
  input  logic                  mem_rvalid_i,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_waddr_o,
  output logic [WORD_SIZE-1:0]  rf_wdata_o,
  output logic                  load_fault_o
`ifdef RISCV_WB_INSTRET_EN
  ,
  output logic [63:0]           instret_o
`endif
);

  wb_state_e state, next_state;

  logic [REG_ADDR_W-1:0] pend_rd;
  logic                  pend_rw;
  logic [2:0]            pend_f3;
  logic [1:0]            pend_addr;

  logic                  accept;
  logic                  capture;
  logic                  retire_alu;
  logic                  retire_load;
  logic [2:0]            align_f3;
  logic [1:0]            align_addr;
  logic [WORD_SIZE-1:0]  align_data;
  logic                  align_fault;
  logic [REG_ADDR_W-1:0] wr_rd;
  logic                  wr_rw;
  logic                  wr_fire;

  assign ready_o = (state == IDLE);
  assign accept  = valid_i & ready_o & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= next_state;
  end

  // While waiting, the aligner and write target come from the latched load.
  always_comb begin
    next_state  = state;
    capture     = 1'b0;
    retire_alu  = 1'b0;
    retire_load = 1'b0;
    align_f3    = funct3_i;
    align_addr  = alu_out_i[1:0];
    wr_rd       = rd_addr_i;
    wr_rw       = reg_write_i;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!is_load_i) begin
            retire_alu = 1'b1;
          end else if (mem_rvalid_i) begin
            retire_load = 1'b1;
          end else begin
            capture    = 1'b1;
            next_state = WAIT_RDATA;
          end
        end
      end
      WAIT_RDATA: begin
        align_f3   = pend_f3;
        align_addr = pend_addr;
        wr_rd      = pend_rd;
        wr_rw      = pend_rw;
        if (mem_rvalid_i) begin
          retire_load = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  riscv_load_align u_align (
    .rdata  (mem_rdata_i),
    .funct3 (align_f3),
    .addr   (align_addr),
    .data   (align_data),
    .fault  (align_fault)
  );

  assign wr_fire = (retire_alu | (retire_load & ~align_fault)) & wr_rw & (wr_rd != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_rd   <= '0;
      pend_rw   <= 1'b0;
      pend_f3   <= '0;
      pend_addr <= '0;
    end else if (capture) begin
      pend_rd   <= rd_addr_i;
      pend_rw   <= reg_write_i;
      pend_f3   <= funct3_i;
      pend_addr <= alu_out_i[1:0];
    end
  end

  // Address and data only move on a real write so forwarding sees stable values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= '0;
      rf_wdata_o   <= '0;
      load_fault_o <= 1'b0;
    end else begin
      rf_we_o      <= wr_fire;
      load_fault_o <= retire_load & align_fault;
      if (wr_fire) begin
        rf_waddr_o <= wr_rd;
        rf_wdata_o <= retire_alu ? alu_out_i : align_data;
      end
    end
  end

`ifdef RISCV_WB_INSTRET_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                        instret_o <= '0;
    else if (retire_alu | retire_load) instret_o <= instret_o + 64'd1;
  end
`endif

endmodule

// File: tb/tb_riscv_wb.sv
// Self-checking bench for riscv_wb: directed scenarios plus random traffic
// compared against a behavioural model of the write-back rules.
module tb_riscv_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic        flush;
  logic [31:0] alu_out;
  logic        is_load;
  logic [2:0]  funct3;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_fault;
`ifdef RISCV_WB_INSTRET_EN
  logic [63:0] instret;
`endif

  int checks = 0;
  int errors = 0;

  bit              m_known = 1'b0;
  bit              m_pending;
  logic [4:0]      m_rd;
  bit              m_rw;
  logic [2:0]      m_f3;
  logic [1:0]      m_addr;
  bit              m_we;
  bit              m_fault;
  logic [4:0]      m_waddr;
  logic [31:0]     m_wdata;
  longint unsigned m_instret;

  always #5 clk = ~clk;

  riscv_wb dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .valid_i      (valid),
    .ready_o      (ready),
    .flush_i      (flush),
    .alu_out_i    (alu_out),
    .is_load_i    (is_load),
    .funct3_i     (funct3),
    .reg_write_i  (reg_write),
    .rd_addr_i    (rd_addr),
    .mem_rdata_i  (mem_rdata),
    .mem_rvalid_i (mem_rvalid),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .load_fault_o (load_fault)
`ifdef RISCV_WB_INSTRET_EN
    ,
    .instret_o    (instret)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Load semantics from the ISA: pick a lane arithmetically, then extend.
  function automatic void load_model(input logic [31:0] rdata, input int f3, input int addr,
                                     output logic [31:0] data, output bit fault);
    int unsigned b, h;
    b = (rdata >> (8 * addr)) & 32'hFF;
    h = (rdata >> (16 * (addr / 2))) & 32'hFFFF;
    data  = 32'd0;
    fault = 1'b0;
    case (f3)
      0: data = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4: data = b;
      1: begin fault = (addr % 2) != 0; data = (h >= 32768) ? h + 32'hFFFF_0000 : h; end
      5: begin fault = (addr % 2) != 0; data = h; end
      2: begin fault = (addr != 0); data = rdata; end
      default: fault = 1'b1;
    endcase
  endfunction

  function automatic void model_load_retire(input logic [4:0] rd, input bit rw, input logic [2:0] f3,
                                            input logic [1:0] addr, input logic [31:0] rdata);
    logic [31:0] d;
    bit          f;
    load_model(rdata, int'(f3), int'(addr), d, f);
    if (f) m_fault = 1'b1;
    else if (rw && rd != 0) begin
      m_we    = 1'b1;
      m_waddr = rd;
      m_wdata = d;
    end
    m_instret++;
  endfunction

  task automatic applyStimulus(input bit rst_v, input bit valid_v, input bit flush_v, input bit load_v,
                               input logic [2:0] f3, input bit rw, input logic [4:0] rd,
                               input logic [31:0] alu, input logic [31:0] rdata, input bit rvalid);
    rst_n      = rst_v;
    valid      = valid_v;
    flush      = flush_v;
    is_load    = load_v;
    funct3     = f3;
    reg_write  = rw;
    rd_addr    = rd;
    alu_out    = alu;
    mem_rdata  = rdata;
    mem_rvalid = rvalid;
    #1;
    if (m_known) checkOutput("ready", {63'd0, ready}, {63'd0, !m_pending});
    if (!rst_v) begin
      m_known   = 1'b1;
      m_pending = 1'b0;
      m_we      = 1'b0;
      m_fault   = 1'b0;
      m_waddr   = '0;
      m_wdata   = '0;
      m_instret = 0;
    end else begin
      m_we    = 1'b0;
      m_fault = 1'b0;
      if (m_pending) begin
        if (rvalid) begin
          model_load_retire(m_rd, m_rw, m_f3, m_addr, rdata);
          m_pending = 1'b0;
        end
      end else if (valid_v && !flush_v) begin
        if (!load_v) begin
          if (rw && rd != 0) begin
            m_we    = 1'b1;
            m_waddr = rd;
            m_wdata = alu;
          end
          m_instret++;
        end else if (rvalid) begin
          model_load_retire(rd, rw, f3, alu[1:0], rdata);
        end else begin
          m_pending = 1'b1;
          m_rd      = rd;
          m_rw      = rw;
          m_f3      = f3;
          m_addr    = alu[1:0];
        end
      end
    end
    @(posedge clk);
    #1;
    if (m_known) begin
      checkOutput("rf_we", {63'd0, rf_we}, {63'd0, m_we});
      checkOutput("load_fault", {63'd0, load_fault}, {63'd0, m_fault});
      checkOutput("rf_waddr", {59'd0, rf_waddr}, {59'd0, m_waddr});
      checkOutput("rf_wdata", {32'd0, rf_wdata}, {32'd0, m_wdata});
`ifdef RISCV_WB_INSTRET_EN
      checkOutput("instret", instret, m_instret);
`endif
    end
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 5'd0, 32'd0, 32'd0, 0);
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 5'd0, 32'd0, 32'd0, 0);
    checkOutput("reset_ready", {63'd0, ready}, 64'd1);
    checkOutput("reset_we", {63'd0, rf_we}, 64'd0);

    // ALU write
    applyStimulus(1, 1, 0, 0, 3'd0, 1, 5'd5, 32'h1234, 32'd0, 0);
    checkOutput("alu_we", {63'd0, rf_we}, 64'd1);
    checkOutput("alu_waddr", {59'd0, rf_waddr}, 64'd5);
    checkOutput("alu_wdata", {32'd0, rf_wdata}, 64'h1234);

    // Same-cycle byte loads, signed and unsigned
    applyStimulus(1, 1, 0, 1, 3'd0, 1, 5'd6, 32'h1000_0003, 32'h80FF_FF00, 1);
    checkOutput("lb_wdata", {32'd0, rf_wdata}, 64'hFFFF_FF80);
    applyStimulus(1, 1, 0, 1, 3'd4, 1, 5'd6, 32'h1000_0003, 32'h80FF_FF00, 1);
    checkOutput("lbu_wdata", {32'd0, rf_wdata}, 64'h0000_0080);

    // Late LHU: stalled until the response shows up
    applyStimulus(1, 1, 0, 1, 3'd5, 1, 5'd7, 32'h2000_0002, 32'h1111_2222, 0);
    for (int i = 0; i < 2; i++) begin
      checkOutput("late_ready", {63'd0, ready}, 64'd0);
      applyStimulus(1, 1, 0, 0, 3'd0, 1, 5'd9, 32'h5555, 32'h3333_4444, 0);
    end
    checkOutput("late_ready", {63'd0, ready}, 64'd0);
    applyStimulus(1, 0, 0, 0, 3'd0, 0, 5'd0, 32'd0, 32'hBEEF_0000, 1);
    checkOutput("late_we", {63'd0, rf_we}, 64'd1);
    checkOutput("late_wdata", {32'd0, rf_wdata}, 64'h0000_BEEF);
    checkOutput("late_ready_after", {63'd0, ready}, 64'd1);

    // Faults: misaligned LW and illegal funct3
    applyStimulus(1, 1, 0, 1, 3'd2, 1, 5'd8, 32'h0000_0102, 32'hDEAD_BEEF, 1);
    checkOutput("lw_mis_we", {63'd0, rf_we}, 64'd0);
    checkOutput("lw_mis_fault", {63'd0, load_fault}, 64'd1);
    applyStimulus(1, 0, 0, 0, 3'd0, 0, 5'd0, 32'd0, 32'd0, 0);
    checkOutput("fault_pulse", {63'd0, load_fault}, 64'd0);
    applyStimulus(1, 1, 0, 1, 3'd3, 1, 5'd8, 32'h0000_0100, 32'hDEAD_BEEF, 1);
    checkOutput("f3_3_fault", {63'd0, load_fault}, 64'd1);

    // Suppression: x0 write, flushed instruction, flush while waiting
    applyStimulus(1, 1, 0, 0, 3'd0, 1, 5'd0, 32'h7777, 32'd0, 0);
    checkOutput("x0_we", {63'd0, rf_we}, 64'd0);
    applyStimulus(1, 1, 1, 0, 3'd0, 1, 5'd12, 32'h8888, 32'd0, 0);
    checkOutput("flush_we", {63'd0, rf_we}, 64'd0);
    applyStimulus(1, 1, 0, 1, 3'd2, 1, 5'd10, 32'h0000_0200, 32'd0, 0);
    applyStimulus(1, 1, 1, 0, 3'd0, 1, 5'd13, 32'h9999, 32'd0, 0);
    applyStimulus(1, 1, 1, 0, 3'd0, 1, 5'd13, 32'h9999, 32'hCAFE_F00D, 1);
    checkOutput("flush_wait_we", {63'd0, rf_we}, 64'd1);
    checkOutput("flush_wait_wdata", {32'd0, rf_wdata}, 64'hCAFE_F00D);
    checkOutput("flush_wait_waddr", {59'd0, rf_waddr}, 64'd10);

    // Reset while waiting abandons the load
    applyStimulus(1, 1, 0, 1, 3'd2, 1, 5'd11, 32'h0000_0300, 32'd0, 0);
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 5'd0, 32'd0, 32'd0, 0);
    applyStimulus(1, 0, 0, 0, 3'd0, 0, 5'd0, 32'd0, 32'h1234_5678, 1);
    checkOutput("rst_wait_we", {63'd0, rf_we}, 64'd0);
    checkOutput("rst_wait_ready", {63'd0, ready}, 64'd1);

    // Four retirements from reset, including an x0 write and a fault
    applyStimulus(1, 1, 0, 0, 3'd0, 1, 5'd1, 32'h1, 32'd0, 0);
    applyStimulus(1, 1, 0, 0, 3'd0, 1, 5'd0, 32'h2, 32'd0, 0);
    applyStimulus(1, 1, 0, 1, 3'd7, 1, 5'd2, 32'h3, 32'd0, 1);
    applyStimulus(1, 1, 0, 1, 3'd2, 1, 5'd3, 32'h4, 32'hABCD_0123, 1);
`ifdef RISCV_WB_INSTRET_EN
    checkOutput("instret_four", instret, 64'd4);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [4:0] rd_r;
      rd_r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      applyStimulus($urandom_range(0, 49) != 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 1) == 1,
                    3'($urandom_range(0, 7)),
                    $urandom_range(0, 3) != 0,
                    rd_r,
                    $urandom,
                    $urandom,
                    $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
